// File: rtl/command_credit_arbiter_pkg.sv
// Shared types and defaults for the PSL command credit arbiter.
// Requester index constants name the fixed order of the AFU command producers.
package command_credit_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF  = 5;
    localparam int unsigned CMD_W_DEF    = 64;
    localparam int unsigned TAG_W_DEF    = 5;
    localparam int unsigned CREDIT_W_DEF = 8;

    localparam int unsigned REQ_WED      = 0;
    localparam int unsigned REQ_READ     = 1;
    localparam int unsigned REQ_WRITE    = 2;
    localparam int unsigned REQ_PF_READ  = 3;
    localparam int unsigned REQ_PF_WRITE = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } arbiter_state_t;

endpackage

// File: rtl/command_credit_arbiter_if.sv
// Bundle of requester, PSL command/response and control signals around the arbiter.
// The master side drives requests and responses; the slave side is the arbiter.
interface command_credit_arbiter_if
    import command_credit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned CMD_W    = CMD_W_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF,
    parameter int unsigned CREDIT_W = CREDIT_W_DEF
) ();

    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                     enabled_in;
    logic                     credit_load;
    logic [CREDIT_W-1:0]      credit_init;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cmd_out_valid;
    logic [CMD_W-1:0]         cmd_out_cmd;
    logic [TAG_W-1:0]         cmd_out_tag;
    logic [SRC_W-1:0]         cmd_out_src;
    logic                     rsp_valid;
    logic [TAG_W-1:0]         rsp_tag;
    logic                     drain_req;
    logic                     drain_done;
    logic [CREDIT_W-1:0]      credits_avail;
    logic [TAG_W:0]           outstanding;
    logic [1:0]               arb_error;

    modport master (
        output enabled_in, credit_load, credit_init, req_valid, req_cmd,
        output rsp_valid, rsp_tag, drain_req,
        input  req_ready, cmd_out_valid, cmd_out_cmd, cmd_out_tag, cmd_out_src,
        input  drain_done, credits_avail, outstanding, arb_error
    );

    modport slave (
        input  enabled_in, credit_load, credit_init, req_valid, req_cmd,
        input  rsp_valid, rsp_tag, drain_req,
        output req_ready, cmd_out_valid, cmd_out_cmd, cmd_out_tag, cmd_out_src,
        output drain_done, credits_avail, outstanding, arb_error
    );

endinterface

// File: rtl/command_credit_arbiter_tag_pool.sv
// Command tag pool: busy bitmap, lowest-index free tag, release on response, busy count.
// Releasing a tag that is not busy is reported and leaves the pool untouched.
module command_credit_arbiter_tag_pool
    import command_credit_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             i_alloc,
    input  logic             i_release,
    input  logic [TAG_W-1:0] i_release_tag,
    output logic [TAG_W-1:0] o_free_tag,
    output logic             o_any_free,
    output logic             o_release_hit,
    output logic [TAG_W:0]   o_count
);

    localparam int unsigned NUM_TAGS = 2 ** TAG_W;

    logic [NUM_TAGS-1:0] r_busy;
    logic [NUM_TAGS-1:0] w_busy_d;
    logic [TAG_W:0]      r_count;
    logic [TAG_W:0]      w_count_d;

    // Scan from the top so the last hit is the lowest free index.
    always_comb begin
        o_free_tag = '0;
        o_any_free = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                o_free_tag = TAG_W'(i);
                o_any_free = 1'b1;
            end
        end
    end

    assign o_release_hit = i_release && r_busy[i_release_tag];

    always_comb begin
        w_busy_d = r_busy;
        if (o_release_hit) begin
            w_busy_d[i_release_tag] = 1'b0;
        end
        if (i_alloc && o_any_free) begin
            w_busy_d[o_free_tag] = 1'b1;
        end
    end

    always_comb begin
        w_count_d = r_count;
        unique case ({i_alloc && o_any_free, o_release_hit})
            2'b10:   w_count_d = r_count + (TAG_W+1)'(1);
            2'b01:   w_count_d = r_count - (TAG_W+1)'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_d;
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/command_credit_arbiter.sv
// Round-robin arbiter sharing the PSL command port between AFU requesters.
// Owns PSL credits, the tag pool, outstanding tracking and the drain handshake.
module command_credit_arbiter
    import command_credit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned CMD_W    = CMD_W_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF,
    parameter int unsigned CREDIT_W = CREDIT_W_DEF
) (
    input  logic                     clock,
    input  logic                     rstn,
    command_credit_arbiter_if.slave  arb_if
);

    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    arbiter_state_t      r_state;
    arbiter_state_t      w_state_d;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic [SRC_W-1:0]    w_rr_ptr_d;
    logic [CREDIT_W-1:0] r_credits;
    logic [CREDIT_W-1:0] w_credits_d;
    logic [1:0]          r_arb_error;
    logic [1:0]          w_arb_error_d;
    logic                r_out_valid;
    logic [CMD_W-1:0]    r_out_cmd;
    logic [TAG_W-1:0]    r_out_tag;
    logic [SRC_W-1:0]    r_out_src;

    logic                w_run;
    logic                w_grant;
    logic                w_found;
    logic [SRC_W-1:0]    w_idx;
    logic [SRC_W-1:0]    w_winner;
    logic [CMD_W-1:0]    w_win_cmd;
    logic [TAG_W-1:0]    w_free_tag;
    logic                w_any_free;
    logic                w_rsp_hit;
    logic [TAG_W:0]      w_outstanding;

    command_credit_arbiter_tag_pool #(
        .TAG_W (TAG_W)
    ) u_tag_pool (
        .clock         (clock),
        .rstn          (rstn),
        .i_alloc       (w_grant),
        .i_release     (arb_if.rsp_valid),
        .i_release_tag (arb_if.rsp_tag),
        .o_free_tag    (w_free_tag),
        .o_any_free    (w_any_free),
        .o_release_hit (w_rsp_hit),
        .o_count       (w_outstanding)
    );

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = '0;
        w_winner = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = SRC_W'((int'(r_rr_ptr) + off) % NUM_REQ);
            if (!w_found && arb_if.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == SRC_W'(i)) begin
                w_win_cmd = arb_if.req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        w_rr_ptr_d = r_rr_ptr;
        if (w_grant) begin
            w_rr_ptr_d = (w_winner == SRC_W'(NUM_REQ - 1)) ? '0 : w_winner + SRC_W'(1);
        end
    end

    always_comb begin
        w_credits_d   = r_credits;
        w_arb_error_d = r_arb_error;
        if (arb_if.credit_load) begin
            w_credits_d = arb_if.credit_init;
        end else if (w_grant && !arb_if.rsp_valid) begin
            w_credits_d = r_credits - CREDIT_W'(1);
        end else if (!w_grant && arb_if.rsp_valid) begin
            if (r_credits == CREDIT_MAX) begin
                w_arb_error_d[0] = 1'b1;
            end else begin
                w_credits_d = r_credits + CREDIT_W'(1);
            end
        end
        if (arb_if.rsp_valid && !w_rsp_hit) begin
            w_arb_error_d[1] = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (arb_if.drain_req) begin
                    w_state_d = StDrain;
                end else if (arb_if.credit_load && arb_if.enabled_in) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (arb_if.drain_req) begin
                    w_state_d = StDrain;
                end else if (!arb_if.enabled_in && (w_outstanding == '0)) begin
                    w_state_d = StIdle;
                end
            end
            StDrain: begin
                if (!arb_if.drain_req && (w_outstanding == '0)) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_run   = (r_state == StRun);
        w_grant = w_run && arb_if.enabled_in && !arb_if.drain_req && w_found
                  && (r_credits != '0) && w_any_free;
        arb_if.drain_done = (r_state == StDrain) && (w_outstanding == '0);
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_if.req_ready[i] = w_grant && (w_winner == SRC_W'(i));
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_credits   <= '0;
            r_arb_error <= '0;
            r_out_valid <= 1'b0;
            r_out_cmd   <= '0;
            r_out_tag   <= '0;
            r_out_src   <= '0;
        end else begin
            r_rr_ptr    <= w_rr_ptr_d;
            r_credits   <= w_credits_d;
            r_arb_error <= w_arb_error_d;
            r_out_valid <= w_grant;
            if (w_grant) begin
                r_out_cmd <= w_win_cmd;
                r_out_tag <= w_free_tag;
                r_out_src <= w_winner;
            end
        end
    end

    assign arb_if.cmd_out_valid = r_out_valid;
    assign arb_if.cmd_out_cmd   = r_out_cmd;
    assign arb_if.cmd_out_tag   = r_out_tag;
    assign arb_if.cmd_out_src   = r_out_src;
    assign arb_if.credits_avail = r_credits;
    assign arb_if.outstanding   = w_outstanding;
    assign arb_if.arb_error     = r_arb_error;

endmodule

// File: tb/tb_command_credit_arbiter.sv
// Directed bench for command_credit_arbiter: vector table plus reset-mid-burst sequence.
module tb_command_credit_arbiter;
    import command_credit_arbiter_pkg::*;

    logic clock = 1'b0;
    logic rstn  = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clock = ~clock;

    command_credit_arbiter_if #(
        .NUM_REQ  (5),
        .CMD_W    (64),
        .TAG_W    (5),
        .CREDIT_W (8)
    ) u_if ();

    command_credit_arbiter #(
        .NUM_REQ  (5),
        .CMD_W    (64),
        .TAG_W    (5),
        .CREDIT_W (8)
    ) u_dut (
        .clock  (clock),
        .rstn   (rstn),
        .arb_if (u_if)
    );

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] init;
        logic [4:0] rv;
        logic       rsp;
        logic [4:0] rtag;
        logic       drn;
        logic [4:0] e_ready;
        logic       e_ov;
        logic [4:0] e_tag;
        logic [2:0] e_src;
        logic [7:0] e_cred;
        logic [5:0] e_out;
        logic       e_dd;
        logic [1:0] e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int unsigned en, ld, init, rv, rsp, rtag, drn,
                       input int unsigned e_ready, e_ov, e_tag, e_src, e_cred, e_out, e_dd,
                       input int unsigned e_err);
        vec_t v;
        v.en = 1'(en);         v.ld = 1'(ld);        v.init = 8'(init);
        v.rv = 5'(rv);         v.rsp = 1'(rsp);      v.rtag = 5'(rtag);
        v.drn = 1'(drn);       v.e_ready = 5'(e_ready);
        v.e_ov = 1'(e_ov);     v.e_tag = 5'(e_tag);  v.e_src = 3'(e_src);
        v.e_cred = 8'(e_cred); v.e_out = 6'(e_out);  v.e_dd = 1'(e_dd);
        v.e_err = 2'(e_err);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] payload(input int unsigned i);
        return {32'hC0DE_0000, 32'(i)};
    endfunction

    task automatic drive(input logic en, ld, input logic [7:0] init, input logic [4:0] rv,
                         input logic rsp, input logic [4:0] rtag, input logic drn);
        u_if.enabled_in  = en;
        u_if.credit_load = ld;
        u_if.credit_init = init;
        u_if.req_valid   = rv;
        u_if.rsp_valid   = rsp;
        u_if.rsp_tag     = rtag;
        u_if.drain_req   = drn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 5; i++) begin
            u_if.req_cmd[i*64 +: 64] = payload(i);
        end
        drive(1'b0, 1'b0, 8'd0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Columns: en ld init rv rsp rtag drn | ready ov tag src cred out dd err
        add(1, 1,   4, 5'b00000, 0, 0, 0,  5'b00000, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0,   0, 5'b01110, 0, 0, 0,  5'b00010, 0, 0, 0, 4, 0, 0, 0);
        add(1, 0,   0, 5'b01110, 0, 0, 0,  5'b00100, 1, 0, 1, 3, 1, 0, 0);
        add(1, 0,   0, 5'b01110, 0, 0, 0,  5'b01000, 1, 1, 2, 2, 2, 0, 0);
        add(1, 0,   0, 5'b01110, 0, 0, 0,  5'b00010, 1, 2, 3, 1, 3, 0, 0);
        add(1, 0,   0, 5'b01110, 0, 0, 0,  5'b00000, 1, 3, 1, 0, 4, 0, 0);
        add(1, 0,   0, 5'b01110, 1, 2, 0,  5'b00000, 0, 0, 0, 0, 4, 0, 0);
        add(1, 0,   0, 5'b01110, 0, 0, 0,  5'b00100, 0, 0, 0, 1, 3, 0, 0);
        add(1, 1,   3, 5'b00000, 0, 0, 0,  5'b00000, 1, 2, 2, 0, 4, 0, 0);
        add(1, 0,   0, 5'b00001, 1, 0, 0,  5'b00001, 0, 0, 0, 3, 4, 0, 0);
        add(1, 0,   0, 5'b00000, 1, 1, 0,  5'b00000, 1, 4, 0, 3, 4, 0, 0);
        add(1, 0,   0, 5'b11111, 0, 0, 1,  5'b00000, 0, 0, 0, 4, 3, 0, 0);
        add(1, 0,   0, 5'b11111, 1, 2, 1,  5'b00000, 0, 0, 0, 4, 3, 0, 0);
        add(1, 0,   0, 5'b11111, 1, 3, 1,  5'b00000, 0, 0, 0, 5, 2, 0, 0);
        add(1, 0,   0, 5'b11111, 1, 4, 1,  5'b00000, 0, 0, 0, 6, 1, 0, 0);
        add(1, 0,   0, 5'b11111, 0, 0, 1,  5'b00000, 0, 0, 0, 7, 0, 1, 0);
        add(1, 0,   0, 5'b11111, 0, 0, 0,  5'b00000, 0, 0, 0, 7, 0, 1, 0);
        add(1, 0,   0, 5'b11111, 0, 0, 0,  5'b00000, 0, 0, 0, 7, 0, 0, 0);
        add(1, 0,   0, 5'b00000, 1, 7, 0,  5'b00000, 0, 0, 0, 7, 0, 0, 0);
        add(1, 0,   0, 5'b00000, 0, 0, 0,  5'b00000, 0, 0, 0, 8, 0, 0, 2);
        add(1, 1, 255, 5'b00000, 0, 0, 0,  5'b00000, 0, 0, 0, 8, 0, 0, 2);
        add(1, 0,   0, 5'b00000, 1, 9, 0,  5'b00000, 0, 0, 0, 255, 0, 0, 2);
        add(0, 0,   0, 5'b11111, 0, 0, 0,  5'b00000, 0, 0, 0, 255, 0, 0, 3);
        add(1, 0,   0, 5'b11111, 0, 0, 0,  5'b00000, 0, 0, 0, 255, 0, 0, 3);

        repeat (2) @(negedge clock);
        #1;
        check("reset ready", u_if.req_ready, 5'd0);
        check("reset valid", u_if.cmd_out_valid, 1'b0);
        check("reset credits", u_if.credits_avail, 8'd0);
        check("reset error", u_if.arb_error, 2'd0);
        rstn = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(negedge clock);
            drive(v.en, v.ld, v.init, v.rv, v.rsp, v.rtag, v.drn);
            #1;
            check($sformatf("v%0d req_ready", k), u_if.req_ready, v.e_ready);
            check($sformatf("v%0d cmd_out_valid", k), u_if.cmd_out_valid, v.e_ov);
            if (v.e_ov) begin
                check($sformatf("v%0d cmd_out_tag", k), u_if.cmd_out_tag, v.e_tag);
                check($sformatf("v%0d cmd_out_src", k), u_if.cmd_out_src, v.e_src);
                check($sformatf("v%0d cmd_out_cmd", k), u_if.cmd_out_cmd, payload(v.e_src));
            end
            check($sformatf("v%0d credits", k), u_if.credits_avail, v.e_cred);
            check($sformatf("v%0d outstanding", k), u_if.outstanding, v.e_out);
            check($sformatf("v%0d drain_done", k), u_if.drain_done, v.e_dd);
            check($sformatf("v%0d arb_error", k), u_if.arb_error, v.e_err);
        end

        // Reset in the middle of a burst clears in-flight tags and errors.
        @(negedge clock);
        drive(1'b1, 1'b1, 8'd4, 5'b11111, 1'b0, 5'd0, 1'b0);
        @(negedge clock);
        u_if.credit_load = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("burst outstanding", u_if.outstanding, 6'd2);
        check("burst valid", u_if.cmd_out_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check("mid reset valid", u_if.cmd_out_valid, 1'b0);
        check("mid reset credits", u_if.credits_avail, 8'd0);
        check("mid reset outstanding", u_if.outstanding, 6'd0);
        check("mid reset error", u_if.arb_error, 2'd0);
        check("mid reset ready", u_if.req_ready, 5'd0);
        check("mid reset tag", u_if.cmd_out_tag, 5'd0);
        @(negedge clock);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("post reset ready c%0d", c), u_if.req_ready, 5'd0);
            check($sformatf("post reset valid c%0d", c), u_if.cmd_out_valid, 1'b0);
            @(negedge clock);
        end
        u_if.rsp_valid = 1'b1;
        u_if.rsp_tag   = 5'd0;
        @(negedge clock);
        u_if.rsp_valid = 1'b0;
        #1;
        check("stale rsp error", u_if.arb_error, 2'b10);
        check("stale rsp credits", u_if.credits_avail, 8'd1);
        check("stale rsp outstanding", u_if.outstanding, 6'd0);
        u_if.credit_load = 1'b1;
        u_if.credit_init = 8'd2;
        @(negedge clock);
        u_if.credit_load = 1'b0;
        #1;
        check("restart ready", u_if.req_ready, 5'b00001);
        @(negedge clock);
        #1;
        check("restart valid", u_if.cmd_out_valid, 1'b1);
        check("restart tag", u_if.cmd_out_tag, 5'd0);
        check("restart src", u_if.cmd_out_src, 3'(REQ_WED));
        check("restart outstanding", u_if.outstanding, 6'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
